// File: rtl/pll_reconfig_pkg.sv
// pll_reconfig_pkg: shared constants, sequencer states and code-to-image mapping
package pll_reconfig_pkg;

    localparam int CHAIN_LEN_DEF = 144;
    localparam int IMAGE_LEN     = 144;
    localparam int IDX_W         = 3;

    localparam logic [IDX_W-1:0] IMG_148M5 = 3'd0;
    localparam logic [IDX_W-1:0] IMG_108M  = 3'd1;
    localparam logic [IDX_W-1:0] IMG_27M   = 3'd2;
    localparam logic [IDX_W-1:0] IMG_25M2  = 3'd3;
    localparam logic [IDX_W-1:0] IMG_144M  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_TRIG,
        S_WAIT_BUSY,
        S_WAIT_LOCK,
        S_DONE
    } state_t;

    function automatic logic [IDX_W-1:0] sel_to_index(input logic [31:0] code);
        return code == 32'h00 ? IMG_148M5 :
               code == 32'h10 ? IMG_144M :
               code == 32'h01 || code == 32'h11 ? IMG_108M :
               code == 32'h03 || code == 32'h13 ? IMG_25M2 :
               IMG_27M;
    endfunction

endpackage

// File: rtl/pll_config_rom.sv
// pll_config_rom: per-frequency PLL scan-chain images with a one-clock registered bit read
module pll_config_rom
    import pll_reconfig_pkg::*;
#(
    parameter int NUM_CONFIGS = 8,
    parameter int CHAIN_LEN   = CHAIN_LEN_DEF,
    parameter int ADDR_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  index,
    input  logic [ADDR_W-1:0] address,
    output logic              q
);

    localparam int BW = $clog2(IMAGE_LEN);

    localparam logic [IMAGE_LEN-1:0] BITS_148M5 = 144'h9A3C_0F12_7E5D_C4B1_2233_8001_F00D_6A5B_13C7;
    localparam logic [IMAGE_LEN-1:0] BITS_108M  = 144'h5B21_E0F3_4C8A_9D67_0110_7FFE_2B4C_D3E5_0A91;
    localparam logic [IMAGE_LEN-1:0] BITS_27M   = 144'h1284_6E0B_F5A3_C90D_7722_0044_8C1E_B6D9_35F0;
    localparam logic [IMAGE_LEN-1:0] BITS_25M2  = 144'h3F7A_0C95_D2E1_486B_A0C3_1FF0_5E29_870B_C64D;
    localparam logic [IMAGE_LEN-1:0] BITS_144M  = 144'hE416_B8D0_2C7F_5A93_061D_F2A8_4B35_9CE7_10A2;

    logic [IMAGE_LEN-1:0] image;
    logic                 in_range;

    // pick the image for this index; unpopulated slots fall back to 27 MHz
    always_comb begin
        image = int'(index) >= NUM_CONFIGS ? BITS_27M :
                index == IMG_148M5 ? BITS_148M5 :
                index == IMG_108M  ? BITS_108M :
                index == IMG_25M2  ? BITS_25M2 :
                index == IMG_144M  ? BITS_144M :
                BITS_27M;
        in_range = int'(address) < CHAIN_LEN && int'(address) < IMAGE_LEN;
    end

    // registered read; addresses past the chain end return 0
    always_ff @(posedge clock) begin
        if (reset) q <= 1'b0;
        else q <= in_range & image[BW'(address)];
    end

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// pll_reconfig_sequencer: drives a full altpll_reconfig scan-chain update whenever the requested code changes
module pll_reconfig_sequencer
    import pll_reconfig_pkg::*;
#(
    parameter int NUM_CONFIGS  = 8,
    parameter int CHAIN_LEN    = CHAIN_LEN_DEF,
    parameter int SEL_W        = 7,
    parameter int ADDR_W       = 8,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [SEL_W-1:0]  cfg_sel,
    input  logic [ADDR_W-1:0] rom_address,
    input  logic              rom_read,
    output logic              rom_q,
    output logic              write_from_rom,
    output logic              reconfig,
    input  logic              reconf_busy,
    input  logic              pll_locked,
    output logic [SEL_W-1:0]  active_sel,
    output logic              seq_busy,
    output logic              done,
    output logic              lock_error
);

    localparam int TW = $clog2(LOCK_TIMEOUT + 4);
    localparam logic [TW-1:0] TRIG_LAST  = TW'(2);
    localparam logic [TW-1:0] TIMER_LAST = TW'(LOCK_TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   req_sel, req_sel_nxt;
    logic [TW-1:0]      timer, timer_nxt;
    logic               seen, seen_nxt;
    logic               lock_error_nxt;
    logic               applied_valid;
    logic               request, expired, rom_bit;

    pll_config_rom #(
        .NUM_CONFIGS (NUM_CONFIGS),
        .CHAIN_LEN   (CHAIN_LEN),
        .ADDR_W      (ADDR_W)
    ) u_rom (
        .clock   (clock),
        .reset   (reset),
        .index   (sel_to_index(32'(req_sel))),
        .address (rom_address),
        .q       (rom_bit)
    );

    assign request        = state == S_IDLE && (!applied_valid || cfg_sel != active_sel) && !reconf_busy;
    assign expired        = timer == TIMER_LAST;
    assign write_from_rom = state == S_LOAD;
    assign reconfig       = state == S_TRIG && timer == TRIG_LAST;
    assign seq_busy       = state != S_IDLE;
    assign done           = state == S_DONE;

    // next state; 'seen' tracks rom_read high in STREAM and reconf_busy high in WAIT_BUSY
    always_comb begin
        state_nxt      = state;
        req_sel_nxt    = req_sel;
        timer_nxt      = timer + 1'b1;
        seen_nxt       = seen;
        lock_error_nxt = lock_error;
        case (state)
            S_IDLE: begin
                seen_nxt  = 1'b0;
                timer_nxt = '0;
                if (request) begin
                    req_sel_nxt = cfg_sel;
                    state_nxt   = S_LOAD;
                end
            end
            S_LOAD: begin
                seen_nxt  = rom_read;
                timer_nxt = '0;
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                seen_nxt = seen | rom_read;
                if (seen && !rom_read) begin
                    timer_nxt = '0;
                    state_nxt = S_TRIG;
                end else if (expired) begin
                    lock_error_nxt = 1'b1;
                    state_nxt      = S_DONE;
                end
            end
            S_TRIG: begin
                if (timer == TRIG_LAST) begin
                    timer_nxt = '0;
                    seen_nxt  = 1'b0;
                    state_nxt = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                seen_nxt = seen | reconf_busy;
                if (seen && !reconf_busy) begin
                    timer_nxt = '0;
                    state_nxt = S_WAIT_LOCK;
                end else if (expired) begin
                    lock_error_nxt = 1'b1;
                    state_nxt      = S_DONE;
                end
            end
            S_WAIT_LOCK: begin
                if (pll_locked) begin
                    lock_error_nxt = 1'b0;
                    state_nxt      = S_DONE;
                end else if (expired) begin
                    lock_error_nxt = 1'b1;
                    state_nxt      = S_DONE;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // state, timer and result registers plus the second rom_q stage
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            req_sel       <= '0;
            timer         <= '0;
            seen          <= 1'b0;
            lock_error    <= 1'b0;
            active_sel    <= '0;
            applied_valid <= 1'b0;
            rom_q         <= 1'b0;
        end else begin
            state      <= state_nxt;
            req_sel    <= req_sel_nxt;
            timer      <= timer_nxt;
            seen       <= seen_nxt;
            lock_error <= lock_error_nxt;
            rom_q      <= rom_bit;
            if (state == S_DONE) begin
                active_sel    <= req_sel;
                applied_valid <= 1'b1;
            end
        end
    end

endmodule
